iq_frame_packer: RTL and testbench

Multi-channel successor to the single-channel IQ streaming path. It captures N_CH decimated I/Q sample pairs on each decimation strobe and serialises them into one framed byte stream for the transmit FIFO/UART. Each frame carries a header, a sequence count, a channel mask, the enabled channels' payload and a checksum. It sits between the CIC decimators and the transmit FIFO, and replaces the fixed 4-byte packet path.

---
 rtl/iq_frame_packer.sv | 196 +++++++++++++++++++
 tb/tb_iq_frame_packer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_frame_packer.sv
// iq_frame_packer
//   On an accepted decimation strobe, captures N_CH I/Q sample pairs and
//   sends them out as one framed byte stream:
//     HDR, SEQ, MASK, payload (enabled channels only, ascending), CHK
//   The checksum byte makes the 8-bit sum of all bytes in a frame zero.
//
// Ports
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_en           strobe accept enable
//   i_strobe       one-cycle pulse, i_data valid for all channels
//   i_data         channel k at [2W(k+1)-1:2Wk], I in the upper W bits
//   i_ch_mask      per-channel include bits, sampled with the strobe
//   i_trig         trigger flag, latched until the next capture
//   i_ready        downstream accepts the byte on o_data
//   o_data/o_valid byte stream, valid/ready handshake
//   o_busy         frame in progress
//   o_overrun      sticky: a strobe arrived while busy
//   o_seq          sequence number of the next frame
module iq_frame_packer #(
  parameter int          N_CH         = 2,
  parameter int          SAMPLE_WIDTH = 16,
  parameter logic [7:0]  ID_BASE      = 8'h08
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_en,
  input  logic                           i_strobe,
  input  logic [2*N_CH*SAMPLE_WIDTH-1:0] i_data,
  input  logic [N_CH-1:0]                i_ch_mask,
  input  logic                           i_trig,
  input  logic                           i_ready,
  output logic [7:0]                     o_data,
  output logic                           o_valid,
  output logic                           o_busy,
  output logic                           o_overrun,
  output logic [7:0]                     o_seq
);

  localparam int CW  = 2 * SAMPLE_WIDTH;          // bits per channel (I+Q)
  localparam int NB  = CW / 8;                    // bytes per channel
  localparam int BW  = $clog2(NB);
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_SEQ, S_MASK, S_PAYLOAD, S_CHK
  } state_e;

  state_e                     state_q, state_d;
  logic [N_CH-1:0][CW-1:0]    data_q, data_d;
  logic [N_CH-1:0]            mask_q, mask_d;
  logic                       trig_q, trig_d;       // trigger bit of the current frame
  logic                       latch_q, latch_d;     // pending trigger
  logic [CHW-1:0]             ch_q, ch_d;
  logic [BW-1:0]              byte_q, byte_d;
  logic [7:0]                 sum_q, sum_d;
  logic [7:0]                 seq_q, seq_d;
  logic                       overrun_q, overrun_d;

  logic                       capture, xfer;
  logic                       first_found, nxt_found;
  logic [CHW-1:0]             first_ch, nxt_ch;
  logic [NB-1:0][7:0]         ch_bytes;
  logic [7:0]                 mask_ext;

  assign capture = (state_q == S_IDLE) && i_strobe && i_en;
  assign xfer    = o_valid && i_ready;

  // Lowest enabled channel, and the next enabled channel above ch_q.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    nxt_found   = 1'b0;
    nxt_ch      = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!first_found && mask_q[k]) begin
        first_found = 1'b1;
        first_ch    = CHW'(k);
      end
      if (!nxt_found && mask_q[k] && (k > int'(ch_q))) begin
        nxt_found = 1'b1;
        nxt_ch    = CHW'(k);
      end
    end
  end

  // State register and datapath flops
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      mask_q    <= '0;
      trig_q    <= 1'b0;
      latch_q   <= 1'b0;
      ch_q      <= '0;
      byte_q    <= '0;
      sum_q     <= '0;
      seq_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      trig_q    <= trig_d;
      latch_q   <= latch_d;
      ch_q      <= ch_d;
      byte_q    <= byte_d;
      sum_q     <= sum_d;
      seq_q     <= seq_d;
      overrun_q <= overrun_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (capture) state_d = S_HDR;
      S_HDR:     if (xfer) state_d = S_SEQ;
      S_SEQ:     if (xfer) state_d = S_MASK;
      S_MASK:    if (xfer) state_d = first_found ? S_PAYLOAD : S_CHK;
      S_PAYLOAD: if (xfer && byte_q == BW'(NB - 1) && !nxt_found) state_d = S_CHK;
      S_CHK:     if (xfer) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    data_d    = data_q;
    mask_d    = mask_q;
    trig_d    = trig_q;
    latch_d   = latch_q;
    ch_d      = ch_q;
    byte_d    = byte_q;
    sum_d     = sum_q;
    seq_d     = seq_q;
    overrun_d = overrun_q;

    // A trigger in the capture cycle both tags this frame and stays pending.
    if (capture) latch_d = i_trig;
    else if (i_trig) latch_d = 1'b1;

    if (capture) begin
      data_d = i_data;
      mask_d = i_ch_mask;
      trig_d = latch_q | i_trig;
      sum_d  = '0;
    end else if (xfer) begin
      sum_d = sum_q + o_data;
    end

    // Any strobe while a frame is in flight is lost, regardless of i_en.
    if (i_strobe && state_q != S_IDLE) overrun_d = 1'b1;

    if (xfer) begin
      case (state_q)
        S_MASK: begin
          ch_d   = first_ch;
          byte_d = '0;
        end
        S_PAYLOAD: begin
          if (byte_q == BW'(NB - 1)) begin
            byte_d = '0;
            if (nxt_found) ch_d = nxt_ch;
          end else begin
            byte_d = byte_q + 1'b1;
          end
        end
        S_CHK:   seq_d = seq_q + 8'd1;
        default: ;
      endcase
    end
  end

  // Outputs: o_data depends only on flops, so it holds during stalls.
  assign ch_bytes = data_q[ch_q];

  always_comb begin
    mask_ext             = '0;
    mask_ext[N_CH-1:0]   = mask_q;
    o_data               = 8'h00;
    case (state_q)
      S_HDR:     o_data = ID_BASE | {3'b000, trig_q, 4'b0000};
      S_SEQ:     o_data = seq_q;
      S_MASK:    o_data = mask_ext;
      S_PAYLOAD: o_data = ch_bytes[BW'(NB - 1) - byte_q];   // MSB first
      S_CHK:     o_data = ~sum_q + 8'd1;
      default:   o_data = 8'h00;
    endcase
    o_valid   = (state_q != S_IDLE);
    o_busy    = (state_q != S_IDLE);
    o_overrun = overrun_q;
    o_seq     = seq_q;
  end

endmodule

// File: tb/tb_iq_frame_packer.sv
// Scoreboard bench for iq_frame_packer (N_CH=2, SAMPLE_WIDTH=16).
// Stimulus pushes expected frame bytes into exp_q; a monitor pops and
// compares on every accepted byte and checks o_data stability in stalls.
module tb_iq_frame_packer;

  localparam int N_CH = 2;
  localparam int W    = 16;

  logic                  clk = 1'b0;
  logic                  rst, en, strobe, trig, ready;
  logic [2*N_CH*W-1:0]   data;
  logic [N_CH-1:0]       mask;
  logic [7:0]            o_data, o_seq;
  logic                  o_valid, o_busy, o_overrun;

  iq_frame_packer #(.N_CH(N_CH), .SAMPLE_WIDTH(W), .ID_BASE(8'h08)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_strobe(strobe), .i_data(data),
    .i_ch_mask(mask), .i_trig(trig), .i_ready(ready), .o_data(o_data),
    .o_valid(o_valid), .o_busy(o_busy), .o_overrun(o_overrun), .o_seq(o_seq)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_seq = 8'd0;
  int         rdy_mode = 0;

  localparam logic [63:0] D0 = 64'h9ABC_DEF0_1234_5678;
  localparam logic [63:0] D1 = 64'hA1B2_C3D4_0F1E_2D3C;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_list(input logic [7:0] b[$]);
    foreach (b[i]) exp_q.push_back(b[i]);
    exp_seq++;
  endtask

  // Reference frame: used where no hand-computed list is given.
  task automatic push_frame(input logic [63:0] d, input logic [1:0] m, input logic t);
    logic [7:0] s;
    logic [31:0] w;
    logic [7:0] b;
    s = 8'h00;
    b = t ? 8'h18 : 8'h08; exp_q.push_back(b); s += b;
    exp_q.push_back(exp_seq); s += exp_seq;
    b = {6'b0, m}; exp_q.push_back(b); s += b;
    for (int k = 0; k < N_CH; k++) begin
      if (m[k]) begin
        w = d[32*k +: 32];
        for (int j = 3; j >= 0; j--) begin
          b = w[8*j +: 8];
          exp_q.push_back(b);
          s += b;
        end
      end
    end
    exp_q.push_back(8'h00 - s);
    exp_seq++;
  endtask

  task automatic strobe_once(input logic [63:0] d, input logic [1:0] m, input logic t);
    data = d; mask = m; trig = t; strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0; trig = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((exp_q.size() != 0 || o_busy) && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 2000) begin
      n_tests++; n_fail++;
      $display("FAIL wait_idle: timeout, %0d bytes outstanding", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Downstream ready: always 1, or 1,0,0,1 then random stalls.
  initial begin
    int idx = 0;
    logic [3:0] pat;
    pat = 4'b1001;
    ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) ready = 1'b1;
      else begin
        ready = (idx < 4) ? pat[3 - idx] : 1'($urandom_range(0, 1));
        idx++;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [7:0] held;
    logic       held_v;
    held_v = 1'b0;
    held   = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v && o_valid) check("stall_hold", o_data, held);
        held_v = 1'b0;
        if (o_valid && ready) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_byte: got %0h, expected none", o_data);
          end else begin
            check("frame_byte", o_data, exp_q.pop_front());
          end
        end else if (o_valid) begin
          held   = o_data;
          held_v = 1'b1;
        end
      end
    end
  end

  initial begin
    int vcnt;
    rst = 1'b1; en = 1'b0; strobe = 1'b0; trig = 1'b0; data = '0; mask = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_overrun", o_overrun, 0);
    check("rst_seq", o_seq, 0);
    check("rst_data", o_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Strobe with i_en=0: ignored, no overrun
    strobe_once(D0, 2'b11, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("en0_busy", o_busy, 0);
    check("en0_overrun", o_overrun, 0);
    en = 1'b1;

    // Frame 1: both channels
    push_list('{8'h08, 8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78,
                8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'hBD});
    strobe_once(D0, 2'b11, 1'b0);
    vcnt = 0;
    repeat (14) begin
      if (o_valid) vcnt++;
      @(posedge clk); #1;
    end
    check("f1_valid_cycles", vcnt, 12);
    check("f1_seq", o_seq, 1);

    // Frame 2: channel 1 only
    push_list('{8'h08, 8'h01, 8'h02, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'hD1});
    strobe_once(D0, 2'b10, 1'b0);
    wait_idle();
    check("f2_seq", o_seq, 2);

    // Frame 3: empty mask, trigger pulse 5 cycles earlier
    trig = 1'b1;
    @(posedge clk); #1;
    trig = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    push_list('{8'h18, 8'h02, 8'h00, 8'hE6});
    strobe_once(D0, 2'b00, 1'b0);
    wait_idle();
    push_list('{8'h08, 8'h03, 8'h00, 8'hF5});   // latch cleared
    strobe_once(D0, 2'b00, 1'b0);
    wait_idle();
    check("f4_seq", o_seq, 4);

    // Trigger coincident with the capture keeps the latch set for one more frame
    push_frame(D1, 2'b01, 1'b1);
    strobe_once(D1, 2'b01, 1'b1);
    wait_idle();
    push_frame(D1, 2'b10, 1'b1);
    strobe_once(D1, 2'b10, 1'b0);
    wait_idle();
    push_frame(D1, 2'b00, 1'b0);
    strobe_once(D1, 2'b00, 1'b0);
    wait_idle();

    // Backpressure
    rdy_mode = 1;
    push_frame(D0, 2'b11, 1'b0);
    strobe_once(D0, 2'b11, 1'b0);
    wait_idle();
    push_frame(D1, 2'b01, 1'b0);
    strobe_once(D1, 2'b01, 1'b0);
    wait_idle();
    rdy_mode = 0;
    @(posedge clk); #1;
    check("stall_seq", o_seq, exp_seq);
    check("pre_overrun", o_overrun, 0);

    // Overrun: strobe 3 cycles into a frame, and one on the CHK transfer
    push_frame(D0, 2'b11, 1'b0);
    strobe_once(D0, 2'b11, 1'b0);          // captured at P0
    repeat (2) @(posedge clk);
    #1;
    strobe = 1'b1;                         // sampled at P3
    @(posedge clk); #1;
    strobe = 1'b0;
    check("ovr_set", o_overrun, 1);
    repeat (8) @(posedge clk);
    #1;
    strobe = 1'b1;                         // sampled at P12 = CHK transfer
    @(posedge clk); #1;
    strobe = 1'b0;
    check("ovr_chk_not_captured", o_busy, 0);
    wait_idle();
    check("ovr_seq", o_seq, exp_seq);
    push_frame(D1, 2'b11, 1'b0);
    strobe_once(D1, 2'b11, 1'b0);
    wait_idle();
    check("ovr_sticky", o_overrun, 1);

    // Sequence wrap
    while (exp_seq != 8'd0) begin
      push_frame(D0, 2'b00, 1'b0);
      strobe_once(D0, 2'b00, 1'b0);
      wait_idle();
    end
    check("seq_wrap", o_seq, 0);
    push_frame(D0, 2'b01, 1'b0);
    strobe_once(D0, 2'b01, 1'b0);
    wait_idle();
    check("seq_after_wrap", o_seq, 1);

    // Reset during PAYLOAD
    push_frame(D0, 2'b11, 1'b0);
    strobe_once(D0, 2'b11, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_seq", o_seq, 0);
    check("mid_rst_overrun", o_overrun, 0);
    exp_seq = 8'd0;
    push_frame(D1, 2'b11, 1'b0);
    strobe_once(D1, 2'b11, 1'b0);
    wait_idle();
    check("post_rst_seq", o_seq, 1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
